// File: rtl/cpu_defs_pkg.sv
// Shared fetch/decode definitions: RISC-V opcode and RVC field constants plus the fetch
// queue entry layout.
package cpu_defs_pkg;

    localparam int unsigned CPU_XLEN = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] RVC_Q1  = 2'b01;
    localparam logic [1:0] RVC_Q2  = 2'b10;
    localparam logic [1:0] INST_32 = 2'b11;

    localparam logic [2:0] RVC_F3_JAL  = 3'b001;
    localparam logic [2:0] RVC_F3_J    = 3'b101;
    localparam logic [2:0] RVC_F3_BEQZ = 3'b110;
    localparam logic [2:0] RVC_F3_BNEZ = 3'b111;
    localparam logic [2:0] RVC_F3_JR   = 3'b100;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] inst;
        logic                is32;
    } fetch_entry_t;

endpackage

// File: rtl/rvc_cf_detect.sv
// Combinational classifier: instruction length (32-bit vs RVC) and whether the word
// transfers control (jal/jalr/branch and their compressed forms).
module rvc_cf_detect
    import cpu_defs_pkg::*;
(
    input  logic [15:0] inst_i,
    output logic        is32_o,
    output logic        is_cf_o
);

    logic [1:0] quad;
    logic [2:0] funct3;
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;

    always_comb begin
        quad    = inst_i[1:0];
        funct3  = inst_i[15:13];
        opcode  = inst_i[6:0];
        rs1     = inst_i[11:7];
        rs2     = inst_i[6:2];
        is32_o  = (quad == INST_32);
        is_cf_o = 1'b0;
        if (is32_o) begin
            is_cf_o = (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
        end else if (quad == RVC_Q1) begin
            is_cf_o = (funct3 == RVC_F3_JAL) || (funct3 == RVC_F3_J) ||
                      (funct3 == RVC_F3_BEQZ) || (funct3 == RVC_F3_BNEZ);
        end else if (quad == RVC_Q2) begin
            // c.jr / c.jalr; rs1==0 encodings are reserved or c.ebreak, not jumps
            is_cf_o = (funct3 == RVC_F3_JR) && (rs2 == 5'd0) && (rs1 != 5'd0);
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: sequential PC generation, RVC-aware length classification and a
// small FIFO decoupling fetch from decode. Fetch halts after control flow until redirected.
module fetch_queue_unit
    import cpu_defs_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rob_clear,
    input  logic [XLEN-1:0]          rob_pc,
    input  logic                     dec_clear,
    input  logic [XLEN-1:0]          dec_pc,
    output logic                     icache_req,
    output logic [XLEN-1:0]          icache_pc,
    input  logic                     icache_valid,
    input  logic [XLEN-1:0]          icache_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic                     out_is32,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    new_entry;
    fetch_entry_t    head_q, head_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            stall_q, stall_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic full;
    logic push;
    logic pop;
    logic write_en;
    logic inst_is32;
    logic inst_is_cf;

    rvc_cf_detect u_cf_detect (
        .inst_i  (icache_inst[15:0]),
        .is32_o  (inst_is32),
        .is_cf_o (inst_is_cf)
    );

    assign full       = (count_q == CW'(DEPTH));
    // Depends only on registered state, so out_ready never reaches icache_req.
    assign icache_req = !stall_q && !full;
    assign icache_pc  = pc_q;
    assign out_valid  = (count_q != '0);
    assign out_count  = count_q;
    assign out_pc     = head_q.pc;
    assign out_inst   = head_q.inst;
    assign out_is32   = head_q.is32;

    assign push     = rdy && icache_req && icache_valid && (icache_inst != '0);
    assign pop      = rdy && out_valid && out_ready;
    assign write_en = push && !rob_clear;

    always_comb begin
        new_entry.pc   = pc_q;
        new_entry.is32 = inst_is32;
        new_entry.inst = inst_is32 ? icache_inst : {{(XLEN-16){1'b0}}, icache_inst[15:0]};
    end

    always_comb begin
        pc_d     = pc_q;
        stall_d  = stall_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        head_d   = head_q;
        if (rdy) begin
            if (rob_clear) begin
                pc_d     = rob_pc;
                stall_d  = 1'b0;
                count_d  = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
            end else begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    pc_d     = pc_q + (inst_is32 ? XLEN'(4) : XLEN'(2));
                    if (inst_is_cf) begin
                        stall_d = 1'b1;
                    end
                end
                // push is impossible while stalled, so this never races a push update
                if (dec_clear && stall_q) begin
                    pc_d    = dec_pc;
                    stall_d = 1'b0;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
                // Register the next head so out_* hold their last value once empty.
                if (count_d != '0) begin
                    if (push && (rd_ptr_d == wr_ptr_q)) begin
                        head_d = new_entry;
                    end else begin
                        head_d = mem_q[rd_ptr_d];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            stall_q  <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            stall_q  <= stall_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule
